// File: rtl/pad_seq_ctrl_pkg.sv
// pad_seq_ctrl shared definitions: sequencer states,
// register map and pad configuration reset value.
package pad_seq_pkg;

  typedef enum logic [1:0] {
    ST_PULL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TURN   = 2'd3
  } seq_state_e;

  localparam logic [1:0] A_DIR    = 2'd0;
  localparam logic [1:0] A_PADCFG = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CMD    = 2'd3;

  localparam logic [7:0] PADCFG_RST = 8'hf0;

endpackage

// File: rtl/pad_seq_ctrl_if.sv
// Register bus between a core-side master and the
// pad sequencer: request/grant with a read-valid return.
interface pad_seq_ctrl_if;

  logic        cfg_req_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_gnt_o;
  logic        cfg_rvalid_o;
  logic [31:0] cfg_rdata_o;

  modport master (
    output cfg_req_i,
    output cfg_we_i,
    output cfg_addr_i,
    output cfg_wdata_i,
    input  cfg_gnt_o,
    input  cfg_rvalid_o,
    input  cfg_rdata_o
  );

  modport slave (
    input  cfg_req_i,
    input  cfg_we_i,
    input  cfg_addr_i,
    input  cfg_wdata_i,
    output cfg_gnt_o,
    output cfg_rvalid_o,
    output cfg_rdata_o
  );

endinterface

// File: rtl/pad_seq_ctrl_cnt.sv
// Loadable 8-bit down-counter timing the PULL, SETTLE
// and TURN intervals of the pad sequencer.
module pad_seq_cnt #(
  parameter logic [7:0] RST_VAL = 8'd16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // high on the final cycle of a loaded interval
  assign o_zero = (r_cnt <= 8'd1);

endmodule

// File: rtl/pad_seq_ctrl.sv
// Pad power-up sequencer: pull, settle, then active pad
// control with break-before-make on direction changes.
module pad_seq_ctrl
  import pad_seq_pkg::*;
#(
  parameter int PULL_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int TURN_CYCLES   = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pad_seq_ctrl_if.slave cfg,
  input  logic [31:0]   gpio_out_i,
  output logic [31:0]   gpio_in_o,
  output logic [31:0]   dq,
  output logic [31:0]   enabq,
  output logic [31:0]   enq,
  input  logic [31:0]   outi,
  output logic [3:0]    ppen,
  output logic [3:0]    puq,
  output logic [3:0]    pwrup_pull_en,
  output logic [3:0]    pwrupzhl,
  output logic [1:0]    seq_state_o
);

  localparam logic [1:0] S_PULL   = ST_PULL;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;
  localparam logic [1:0] S_ACTIVE = ST_ACTIVE;
  localparam logic [1:0] S_TURN   = ST_TURN;

  localparam logic [7:0] C_PULL   = 8'(PULL_CYCLES);
  localparam logic [7:0] C_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [7:0] C_TURN   = 8'(TURN_CYCLES);

  logic [1:0]  r_state;
  logic [31:0] r_dir;
  logic [31:0] r_dir_old;
  logic [7:0]  r_padcfg;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic [1:0]  w_nstate;
  logic        w_load;
  logic [7:0]  w_lval;
  logic        w_zero;
  logic        w_gnt;
  logic        w_wr;
  logic        w_rd;
  logic        w_busy;
  logic        w_restart;
  logic        w_dir_wr;
  logic        w_dir_chg;
  logic [31:0] w_rdata;
  logic [31:0] w_enabq;
  logic [31:0] w_enq;
  logic [3:0]  w_pull;
  logic [3:0]  w_zhl;

  assign w_gnt  = cfg.cfg_req_i && (r_state != S_TURN);
  assign w_wr   = w_gnt && cfg.cfg_we_i;
  assign w_rd   = w_gnt && !cfg.cfg_we_i;
  assign w_busy = (r_state != S_ACTIVE);

  assign w_restart = w_wr && (cfg.cfg_addr_i == A_CMD)
                     && cfg.cfg_wdata_i[0];
  assign w_dir_wr  = w_wr && (cfg.cfg_addr_i == A_DIR);
  assign w_dir_chg = w_dir_wr && (r_state == S_ACTIVE)
                     && (cfg.cfg_wdata_i != r_dir);

  pad_seq_cnt #(
    .RST_VAL (C_PULL)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_load (w_load),
    .i_val  (w_lval),
    .o_zero (w_zero)
  );

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    w_lval   = C_PULL;
    if (w_restart) begin
      w_nstate = S_PULL;
      w_load   = 1'b1;
      w_lval   = C_PULL;
    end else begin
      unique case (r_state)
        S_PULL: begin
          if (w_zero) begin
            w_nstate = S_SETTLE;
            w_load   = 1'b1;
            w_lval   = C_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_zero) w_nstate = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_dir_chg) begin
            w_nstate = S_TURN;
            w_load   = 1'b1;
            w_lval   = C_TURN;
          end
        end
        default: begin
          if (w_zero) w_nstate = S_ACTIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_PULL;
    end else begin
      r_state <= w_nstate;
    end
  end

  // r_dir takes the new value at once; r_dir_old feeds the TURN overlap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dir     <= '0;
      r_dir_old <= '0;
      r_padcfg  <= PADCFG_RST;
    end else begin
      if (w_dir_wr) begin
        r_dir     <= cfg.cfg_wdata_i;
        r_dir_old <= r_dir;
      end
      if (w_wr && (cfg.cfg_addr_i == A_PADCFG)) begin
        r_padcfg <= cfg.cfg_wdata_i[7:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (cfg.cfg_addr_i)
      A_DIR:    w_rdata = r_dir;
      A_PADCFG: w_rdata = {24'd0, r_padcfg};
      A_STATUS: w_rdata = {29'd0, w_busy, r_state};
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= w_rd ? w_rdata : 32'd0;
    end
  end

  always_comb begin
    w_enabq = '0;
    w_enq   = '0;
    w_pull  = '0;
    w_zhl   = '0;
    unique case (r_state)
      S_PULL: begin
        w_pull = 4'hf;
        w_zhl  = 4'hf;
      end
      S_SETTLE: begin
        w_zhl = 4'hf;
        w_enq = ~r_dir;
      end
      S_ACTIVE: begin
        w_enabq = r_dir;
        w_enq   = ~r_dir;
      end
      default: begin
        w_enabq = r_dir_old & r_dir;
        w_enq   = ~r_dir_old & ~r_dir;
      end
    endcase
  end

  assign cfg.cfg_gnt_o    = w_gnt;
  assign cfg.cfg_rvalid_o = r_rvalid;
  assign cfg.cfg_rdata_o  = r_rdata;

  assign enabq         = w_enabq;
  assign enq           = w_enq;
  assign dq            = ~(gpio_out_i & w_enabq);
  assign gpio_in_o     = outi & w_enq;
  assign pwrup_pull_en = w_pull;
  assign pwrupzhl      = w_zhl;
  assign ppen          = r_padcfg[3:0];
  assign puq           = r_padcfg[7:4];
  assign seq_state_o   = r_state;

endmodule

// File: tb/tb_pad_seq_ctrl.sv
// Bench for pad_seq_ctrl: directed scenarios plus a
// randomized run against a timeline-based reference model.
module tb_pad_seq_ctrl;

  localparam int P = 16;
  localparam int S = 8;
  localparam int T = 2;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;
  logic [31:0] dq;
  logic [31:0] enabq;
  logic [31:0] enq;
  logic [31:0] outi;
  logic [3:0]  ppen;
  logic [3:0]  puq;
  logic [3:0]  pull_en;
  logic [3:0]  zhl;
  logic [1:0]  state;

  int n_chk;
  int n_pass;

  pad_seq_ctrl_if bus ();

  pad_seq_ctrl #(
    .PULL_CYCLES   (P),
    .SETTLE_CYCLES (S),
    .TURN_CYCLES   (T)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg           (bus),
    .gpio_out_i    (gpio_out),
    .gpio_in_o     (gpio_in),
    .dq            (dq),
    .enabq         (enabq),
    .enq           (enq),
    .outi          (outi),
    .ppen          (ppen),
    .puq           (puq),
    .pwrup_pull_en (pull_en),
    .pwrupzhl      (zhl),
    .seq_state_o   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic req, input logic we,
                       input logic [1:0] a,
                       input logic [31:0] d);
    bus.cfg_req_i   = req;
    bus.cfg_we_i    = we;
    bus.cfg_addr_i  = a;
    bus.cfg_wdata_i = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    gpio_out = 32'hdead_beef;
    outi = 32'hffff_ffff;
    @(negedge clk);
    #1;
    n_chk++;
    if (state !== 2'd0)
      $display("FAIL rst_state act=%0h exp=0", state);
    else n_pass++;
    n_chk++;
    if ({pull_en, zhl} !== 8'hff)
      $display("FAIL rst_pwrup act=%0h exp=ff", {pull_en, zhl});
    else n_pass++;
    n_chk++;
    if ({ppen, puq} !== 8'h0f)
      $display("FAIL rst_padcfg act=%0h exp=0f", {ppen, puq});
    else n_pass++;
    n_chk++;
    if ({enabq, enq} !== 64'd0)
      $display("FAIL rst_en act=%0h exp=0", {enabq, enq});
    else n_pass++;
    n_chk++;
    if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== 33'd0)
      $display("FAIL rst_rd act=%0h exp=0",
               {bus.cfg_rvalid_o, bus.cfg_rdata_o});
    else n_pass++;
    n_chk++;
    if (dq !== 32'hffff_ffff)
      $display("FAIL rst_dq act=%0h exp=ffffffff", dq);
    else n_pass++;
  endtask

  task automatic test_sequence;
    logic [3:0] e_pull;
    logic [3:0] e_zhl;
    logic [1:0] e_st;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      e_pull = (c < P) ? 4'hf : 4'h0;
      e_zhl  = (c < P + S) ? 4'hf : 4'h0;
      e_st   = (c < P) ? 2'd0 : (c < P + S) ? 2'd1 : 2'd2;
      n_chk++;
      if ({pull_en, zhl, state} !== {e_pull, e_zhl, e_st})
        $display("FAIL seq_c%0d act=%0h exp=%0h", c,
                 {pull_en, zhl, state}, {e_pull, e_zhl, e_st});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_turn;
    drive(1'b1, 1'b1, 2'd0, 32'h0000_00ff);
    #1;
    n_chk++;
    if (bus.cfg_gnt_o !== 1'b1)
      $display("FAIL turn_wgnt act=%0b exp=1", bus.cfg_gnt_o);
    else n_pass++;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd1, 32'd0);
    for (int c = 0; c < T; c++) begin
      #1;
      n_chk++;
      if ({state, bus.cfg_gnt_o} !== {2'd3, 1'b0})
        $display("FAIL turn_st%0d act=%0h exp=6", c,
                 {state, bus.cfg_gnt_o});
      else n_pass++;
      n_chk++;
      if ({enabq, enq} !== {32'd0, 32'hffff_ff00})
        $display("FAIL turn_en%0d act=%0h exp=%0h", c,
                 {enabq, enq}, {32'd0, 32'hffff_ff00});
      else n_pass++;
      if (c == 0) begin
        n_chk++;
        if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== {1'b1, 32'd0})
          $display("FAIL turn_wack act=%0h exp=100000000",
                   {bus.cfg_rvalid_o, bus.cfg_rdata_o});
        else n_pass++;
      end
      @(negedge clk);
    end
    #1;
    n_chk++;
    if ({state, bus.cfg_gnt_o} !== {2'd2, 1'b1})
      $display("FAIL turn_done act=%0h exp=5",
               {state, bus.cfg_gnt_o});
    else n_pass++;
    n_chk++;
    if ({enabq, enq} !== {32'h0000_00ff, 32'hffff_ff00})
      $display("FAIL turn_new act=%0h exp=%0h", {enabq, enq},
               {32'h0000_00ff, 32'hffff_ff00});
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    n_chk++;
    if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== {1'b1, 32'hf0})
      $display("FAIL turn_rd act=%0h exp=1000000f0",
               {bus.cfg_rvalid_o, bus.cfg_rdata_o});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_gpio;
    gpio_out = 32'h0000_000f;
    outi = 32'hffff_ffff;
    drive(1'b1, 1'b1, 2'd1, 32'h0000_00a5);
    #1;
    n_chk++;
    if (dq !== 32'hffff_fff0)
      $display("FAIL gpio_dq act=%0h exp=fffffff0", dq);
    else n_pass++;
    n_chk++;
    if (gpio_in !== 32'hffff_ff00)
      $display("FAIL gpio_in act=%0h exp=ffffff00", gpio_in);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    n_chk++;
    if ({ppen, puq} !== 8'h5a)
      $display("FAIL gpio_padcfg act=%0h exp=5a", {ppen, puq});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_restart;
    drive(1'b1, 1'b1, 2'd3, 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'd0);
    #1;
    n_chk++;
    if (state !== 2'd0)
      $display("FAIL rs_state act=%0h exp=0", state);
    else n_pass++;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 32'd0);
    #1;
    n_chk++;
    if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== {1'b1, 32'h4})
      $display("FAIL rs_status act=%0h exp=100000004",
               {bus.cfg_rvalid_o, bus.cfg_rdata_o});
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    n_chk++;
    if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== {1'b1, 32'hff})
      $display("FAIL rs_dir act=%0h exp=1000000ff",
               {bus.cfg_rvalid_o, bus.cfg_rdata_o});
    else n_pass++;
    n_chk++;
    if ({ppen, puq} !== 8'h5a)
      $display("FAIL rs_padcfg act=%0h exp=5a", {ppen, puq});
    else n_pass++;
    repeat (30) @(negedge clk);
    #1;
    n_chk++;
    if (state !== 2'd2)
      $display("FAIL rs_active act=%0h exp=2", state);
    else n_pass++;
  endtask

  task automatic test_reset_in_turn;
    drive(1'b1, 1'b1, 2'd0, 32'h0000_ff00);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    n_chk++;
    if (state !== 2'd3)
      $display("FAIL rt_turn act=%0h exp=3", state);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({state, pull_en, zhl, ppen, puq} !== {2'd0, 16'hff0f})
      $display("FAIL rt_ctl act=%0h exp=0ff0f",
               {state, pull_en, zhl, ppen, puq});
    else n_pass++;
    n_chk++;
    if ({enabq, enq, dq} !== {64'd0, 32'hffff_ffff})
      $display("FAIL rt_pads act=%0h exp=ffffffff",
               {enabq, enq, dq});
    else n_pass++;
    n_chk++;
    if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== 33'd0)
      $display("FAIL rt_rd act=%0h exp=0",
               {bus.cfg_rvalid_o, bus.cfg_rdata_o});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    n_chk++;
    if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== {1'b1, 32'd0})
      $display("FAIL rt_dir act=%0h exp=100000000",
               {bus.cfg_rvalid_o, bus.cfg_rdata_o});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    int          t;
    int          tl;
    logic [31:0] md;
    logic [31:0] mo;
    logic [7:0]  mp;
    logic        mrv;
    logic [31:0] mrd;
    logic [31:0] nrd;
    logic        pp;
    logic        sp;
    logic        tp;
    logic        eg;
    logic [1:0]  es;
    logic [31:0] ea;
    logic [31:0] ee;
    logic [15:0] ec;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    #2;
    @(negedge clk);
    rst = 1'b0;
    t = 0; tl = 0; md = '0; mo = '0; mp = 8'hf0;
    mrv = 1'b0; mrd = '0;
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom);
      if (bus.cfg_addr_i == 2'd3)
        bus.cfg_wdata_i[0] = ($urandom_range(0, 15) == 0);
      if (bus.cfg_addr_i == 2'd0 && $urandom_range(0, 3) == 0)
        bus.cfg_wdata_i = md;
      gpio_out = $urandom;
      outi = $urandom;
      #1;
      pp = (t < P);
      sp = !pp && (t < P + S);
      tp = (tl > 0);
      es = pp ? 2'd0 : sp ? 2'd1 : tp ? 2'd3 : 2'd2;
      eg = bus.cfg_req_i && !tp;
      ea = (!pp && !sp && !tp) ? md : tp ? (mo & md) : 32'd0;
      ee = pp ? 32'd0 : tp ? (~mo & ~md) : ~md;
      ec = {mp[3:0], mp[7:4], pp ? 4'hf : 4'h0,
            (pp || sp) ? 4'hf : 4'h0};
      n_chk++;
      if ({state, bus.cfg_gnt_o} !== {es, eg})
        $display("FAIL rnd%0d_st act=%0h exp=%0h", i,
                 {state, bus.cfg_gnt_o}, {es, eg});
      else n_pass++;
      n_chk++;
      if ({enabq, enq} !== {ea, ee})
        $display("FAIL rnd%0d_en act=%0h exp=%0h", i,
                 {enabq, enq}, {ea, ee});
      else n_pass++;
      n_chk++;
      if ({dq, gpio_in} !== {~(gpio_out & ea), outi & ee})
        $display("FAIL rnd%0d_io act=%0h exp=%0h", i,
                 {dq, gpio_in}, {~(gpio_out & ea), outi & ee});
      else n_pass++;
      n_chk++;
      if ({ppen, puq, pull_en, zhl} !== ec)
        $display("FAIL rnd%0d_ctl act=%0h exp=%0h", i,
                 {ppen, puq, pull_en, zhl}, ec);
      else n_pass++;
      n_chk++;
      if ({bus.cfg_rvalid_o, bus.cfg_rdata_o} !== {mrv, mrd})
        $display("FAIL rnd%0d_rd act=%0h exp=%0h", i,
                 {bus.cfg_rvalid_o, bus.cfg_rdata_o}, {mrv, mrd});
      else n_pass++;
      nrd = 32'd0;
      if (eg && !bus.cfg_we_i) begin
        case (bus.cfg_addr_i)
          2'd0:    nrd = md;
          2'd1:    nrd = {24'd0, mp};
          2'd2:    nrd = {29'd0, (es != 2'd2), es};
          default: nrd = 32'd0;
        endcase
      end
      if (tl > 0) tl--;
      if (t < P + S) t++;
      if (eg && bus.cfg_we_i) begin
        if (bus.cfg_addr_i == 2'd3 && bus.cfg_wdata_i[0]) begin
          t = 0;
        end else if (bus.cfg_addr_i == 2'd0) begin
          if (!pp && !sp && !tp && bus.cfg_wdata_i != md) begin
            mo = md;
            tl = T;
          end
          md = bus.cfg_wdata_i;
        end else if (bus.cfg_addr_i == 2'd1) begin
          mp = bus.cfg_wdata_i[7:0];
        end
      end
      mrv = eg;
      mrd = nrd;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset;
    test_sequence;
    test_turn;
    test_gpio;
    test_restart;
    test_reset_in_turn;
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
